// File: rtl/mcp3202_pkg.sv
// rtl/mcp3202_pkg.sv - shared types and frame constants for the MCP3202 SPI master
package mcp3202_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        XFER,
        CS_HOLD
    } state_t;

    localparam int ADC_BITS  = 12;
    localparam int N_CLK_MSB = 18;
    localparam int N_CLK_LSB = 29;

    // Rising-edge indices within a frame
    localparam int START_R = 0;
    localparam int SGL_R   = 1;
    localparam int ODD_R   = 2;
    localparam int MSBF_R  = 3;
    localparam int NULL_R  = 5;
    localparam int B11_R   = 6;
    localparam int B0_R    = 17;

    // MOSI value driven on rising edge idx: start bit, then the three config bits, then zeros
    function automatic logic mosi_bit(
        input logic [4:0] idx,
        input logic       sgl_diff,
        input logic       odd_sign,
        input logic       msbf
    );
        logic b;
        b = 1'b0;
        if (idx == 5'(START_R)) b = 1'b1;
        if (idx == 5'(SGL_R))   b = sgl_diff;
        if (idx == 5'(ODD_R))   b = odd_sign;
        if (idx == 5'(MSBF_R))  b = msbf;
        return b;
    endfunction

endpackage

// File: rtl/mcp3202_spi_master_spi_clk_gen.sv
// rtl/mcp3202_spi_master_spi_clk_gen.sv - enabled half-period divider producing spi_clk and edge strobes
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic spi_clk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick     = en && (cnt == LAST);
    // Strobes mark the clk cycle whose closing edge makes the toggle
    assign rise_stb = tick && !spi_clk;
    assign fall_stb = tick && spi_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            spi_clk <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            spi_clk <= 1'b0;
        end else if (tick) begin
            cnt     <= '0;
            spi_clk <= !spi_clk;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mcp3202_spi_master.sv
// rtl/mcp3202_spi_master.sv - MCP3202 conversion-frame controller with LSB-first tail check
module mcp3202_spi_master
    import mcp3202_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int CS_HIGH_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sgl_diff,
    input  logic                odd_sign,
    input  logic                msbf,
    output logic                busy,
    output logic [ADC_BITS-1:0] adc_data,
    output logic                data_valid,
    output logic                lsb_err,
    output logic                spi_clk,
    output logic                cs,
    output logic                din,
    input  logic                dout
);

    localparam int HW = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;

    state_t state, next_state;

    logic                gen_en;
    logic                rise_stb;
    logic                fall_stb;
    logic                accept;
    logic                sgl_q, odd_q, msbf_q;
    logic [4:0]          edge_cnt;
    logic [4:0]          last_edge;
    logic [ADC_BITS-1:0] shift;
    logic [3:0]          tail_idx;
    logic                err_q;
    logic                done_q;
    logic [HW-1:0]       hold_cnt;

    assign gen_en    = (state == CS_SETUP) || (state == XFER);
    assign accept    = (state == IDLE) && start;
    assign busy      = (state != IDLE);
    assign last_edge = msbf_q ? 5'(N_CLK_MSB - 1) : 5'(N_CLK_LSB - 1);
    // r18..r28 carry B1..B11, so the stored-word index is edge - 17
    assign tail_idx  = 4'(edge_cnt - 5'(B0_R));

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (gen_en),
        .spi_clk  (spi_clk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start)    next_state = CS_SETUP;
            CS_SETUP: if (rise_stb) next_state = XFER;
            XFER:     if (done_q)   next_state = CS_HOLD;
            CS_HOLD:  if (hold_cnt == HW'(CS_HIGH_CYC - 1)) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs       <= 1'b1;
            hold_cnt <= '0;
        end else begin
            cs       <= !((next_state == CS_SETUP) || (next_state == XFER));
            hold_cnt <= (state == CS_HOLD) ? hold_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgl_q    <= 1'b0;
            odd_q    <= 1'b0;
            msbf_q   <= 1'b1;
            edge_cnt <= '0;
            shift    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            din      <= 1'b0;
        end else if (accept) begin
            sgl_q    <= sgl_diff;
            odd_q    <= odd_sign;
            msbf_q   <= msbf;
            edge_cnt <= '0;
            shift    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (rise_stb) begin
                din <= mosi_bit(edge_cnt, sgl_q, odd_q, msbf_q);
                // dout is sampled before the toggle; the ADC moved it on the previous falling edge
                if (edge_cnt >= 5'(B11_R) && edge_cnt <= 5'(B0_R)) begin
                    shift <= {shift[ADC_BITS-2:0], dout};
                end else if (!msbf_q && edge_cnt > 5'(B0_R) && dout != shift[tail_idx]) begin
                    err_q <= 1'b1;
                end
            end
            if (fall_stb) begin
                if (edge_cnt == last_edge) done_q <= 1'b1;
                else                       edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid <= 1'b0;
            adc_data   <= '0;
            lsb_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == XFER && done_q) begin
                data_valid <= 1'b1;
                adc_data   <= shift;
                lsb_err    <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_mcp3202_spi_master.sv
// tb/tb_mcp3202_spi_master.sv - directed self-checking bench with an MCP3202 slave model
module tb_mcp3202_spi_master;

    localparam int C   = 4;
    localparam int CSH = 8;
    localparam logic [11:0] WORD = 12'hAAF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgl_diff, odd_sign, msbf;
    logic        busy;
    logic [11:0] adc_data;
    logic        data_valid;
    logic        lsb_err;
    logic        spi_clk;
    logic        cs;
    logic        din;
    logic        dout;

    int n_checks = 0;
    int n_fail   = 0;

    // slave model state
    logic model_rst = 1'b0;
    logic inject    = 1'b0;
    logic exp_sgl, exp_odd, exp_msbf;
    logic sck_q     = 1'b0;
    logic mmsbf     = 1'b1;
    int   rise_cnt  = 0;
    int   fall_cnt  = 0;
    int   last_falls = 0;

    always #5 clk = ~clk;

    mcp3202_spi_master #(
        .CLK_DIV     (C),
        .CS_HIGH_CYC (CSH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sgl_diff   (sgl_diff),
        .odd_sign   (odd_sign),
        .msbf       (msbf),
        .busy       (busy),
        .adc_data   (adc_data),
        .data_valid (data_valid),
        .lsb_err    (lsb_err),
        .spi_clk    (spi_clk),
        .cs         (cs),
        .din        (din),
        .dout       (dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // MCP3202 slave: samples din and shifts dout on spi_clk falling edges, seen from the negedge of clk
    always @(negedge clk) begin
        int k;
        int j;
        if (model_rst || cs) begin
            if (fall_cnt != 0) last_falls = fall_cnt;
            rise_cnt = 0;
            fall_cnt = 0;
            dout     = 1'b0;
            mmsbf    = 1'b1;
        end else begin
            if (spi_clk && !sck_q) rise_cnt++;
            if (!spi_clk && sck_q) begin
                k = fall_cnt;
                if (k == 0) check("din_start", din, 1'b1);
                if (k == 1) check("din_sgl", din, exp_sgl);
                if (k == 2) check("din_odd", din, exp_odd);
                if (k == 3) begin
                    check("din_msbf", din, exp_msbf);
                    mmsbf = din;
                end
                fall_cnt++;
                j = k + 1;
                dout = 1'b0;
                if (j >= 6 && j <= 17)              dout = WORD[17 - j];
                else if (j >= 18 && j <= 28 && !mmsbf) dout = WORD[j - 17];
                if (inject && j == 20) dout = ~dout;
            end
        end
        sck_q = spi_clk;
    end

    task automatic run_frame(input logic s, input logic o, input logic m,
                             input logic inj, input logic poke, input logic exp_err);
        int rel;
        int n;
        int bad;
        exp_sgl  = s;
        exp_odd  = o;
        exp_msbf = m;
        inject   = inj;
        @(negedge clk);
        sgl_diff = s; odd_sign = o; msbf = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sgl_diff = ~s; odd_sign = ~o; msbf = ~m;
        check("cs_after_accept", cs, 1'b0);
        check("busy_after_accept", busy, 1'b1);
        rel = 0;
        while (!data_valid && rel < 2000) begin
            start = (poke && rise_cnt == 4 && rel < 40) ? 1'b1 : 1'b0;
            @(negedge clk);
            rel++;
        end
        start = 1'b0;
        check("dv_latency", rel, m ? 1 + 36 * C : 1 + 58 * C);
        check("adc_data", adc_data, WORD);
        check("lsb_err", lsb_err, exp_err);
        check("cs_high_at_dv", cs, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            start = (poke && n == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("hold_len", n, CSH);
        check("fall_count", last_falls, m ? 18 : 29);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || !cs || data_valid) bad++;
        end
        check("idle_after_frame", bad, 0);
        inject = 1'b0;
    endtask

    initial begin
        int w;
        int dv_seen;
        rst = 1'b1; start = 1'b0; sgl_diff = 1'b0; odd_sign = 1'b0; msbf = 1'b1;
        exp_sgl = 1'b0; exp_odd = 1'b0; exp_msbf = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_spi_clk", spi_clk, 1'b0);
        check("rst_cs", cs, 1'b1);
        check("rst_din", din, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dv", data_valid, 1'b0);
        check("rst_lsb_err", lsb_err, 1'b0);
        check("rst_adc_data", adc_data, 12'h000);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_rst_cs", cs, 1'b1);
        check("idle_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        run_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // abort mid-frame after r10
        exp_sgl = 1'b1; exp_odd = 1'b0; exp_msbf = 1'b0;
        @(negedge clk);
        sgl_diff = 1'b1; odd_sign = 1'b0; msbf = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (rise_cnt < 11 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("reach_r10", rise_cnt, 11);
        rst = 1'b1;
        model_rst = 1'b1;
        #1;
        check("abort_cs", cs, 1'b1);
        check("abort_spi_clk", spi_clk, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_adc_data", adc_data, 12'h000);
        dv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_valid) dv_seen++;
        end
        rst = 1'b0;
        model_rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (data_valid || busy) dv_seen++;
        end
        check("abort_no_dv", dv_seen, 0);

        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
